// File: rtl/ysyx_210544_mmio_initiator_pkg.sv
// Shared constants for the MMIO initiator: device addresses, funct3 size/sign codes, helpers.
package ysyx_210544_mmio_initiator_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [XLEN-1:0] DEV_RTC      = 64'h0000_0000_a000_0048;
    localparam logic [XLEN-1:0] DEV_MTIME    = 64'h0000_0000_0200_bff8;
    localparam logic [XLEN-1:0] DEV_MTIMECMP = 64'h0000_0000_0200_4000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Byte-lane mask of an access starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0f;
            default: size_mask = 8'hff;
        endcase
    endfunction

    function automatic logic is_dev(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] dw;
        dw     = {a[XLEN-1:3], 3'b000};
        is_dev = (dw == DEV_RTC) || (dw == DEV_MTIME) || (dw == DEV_MTIMECMP);
    endfunction

endpackage

// File: rtl/ysyx_210544_mmio_initiator_if.sv
// Start/req/ack device port between the MEM-stage initiator and an MMIO responder.
interface ysyx_210544_mmio_initiator_if;
    logic        o_start;
    logic        o_ack;
    logic        o_ren;
    logic        o_wen;
    logic [63:0] o_addr;
    logic [63:0] o_wdata;
    logic        i_req;
    logic [63:0] i_rdata;

    modport master (output o_start, o_ack, o_ren, o_wen, o_addr, o_wdata,
                    input  i_req, i_rdata);
    modport slave  (input  o_start, o_ack, o_ren, o_wen, o_addr, o_wdata,
                    output i_req, i_rdata);
endinterface

// File: rtl/ysyx_210544_mmio_lane.sv
// Byte-lane logic: load extract with sign/zero extension, and store merge into a doubleword.
module ysyx_210544_mmio_lane
    import ysyx_210544_mmio_initiator_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] dword,
    input  logic [63:0] wdata,
    output logic [63:0] rdata_c,
    output logic [63:0] merged_c
);
    logic [63:0] rot;
    logic [63:0] wrot;
    logic [7:0]  bmask;
    logic [7:0]  smask;

    // Rotations keep misaligned lanes wrapping inside the same doubleword.
    always_comb begin
        smask = size_mask(funct3);
        rot   = 64'({dword, dword} >> {off, 3'b000});
        wrot  = 64'(({wdata, wdata} << {off, 3'b000}) >> 64);
        bmask = 8'(({smask, smask} << off) >> 8);

        case (funct3)
            F3_B:    rdata_c = {{56{rot[7]}}, rot[7:0]};
            F3_H:    rdata_c = {{48{rot[15]}}, rot[15:0]};
            F3_W:    rdata_c = {{32{rot[31]}}, rot[31:0]};
            F3_BU:   rdata_c = {56'h0, rot[7:0]};
            F3_HU:   rdata_c = {48'h0, rot[15:0]};
            F3_WU:   rdata_c = {32'h0, rot[31:0]};
            F3_D:    rdata_c = rot;
            default: rdata_c = rot;
        endcase

        merged_c = dword;
        for (int i = 0; i < 8; i++) begin
            if (bmask[i]) merged_c[i*8 +: 8] = wrot[i*8 +: 8];
        end
    end
endmodule

// File: rtl/ysyx_210544_mmio_initiator.sv
// MEM-stage MMIO initiator: one load/store per transaction, read-modify-write for narrow stores.
module ysyx_210544_mmio_initiator
    import ysyx_210544_mmio_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic        o_hit,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [63:0] o_rdata,
    ysyx_210544_mmio_initiator_if.master bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ACK} state_e;

    state_e             state_q, state_d;
    logic               phase_q, phase_d;
    logic               load_q, load_d;
    logic [2:0]         f3_q, f3_d;
    logic [63:0]        addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [63:0]        data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               rmw;

    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               start_q, start_d, ack_q, ack_d, ren_q, ren_d, wen_q, wen_d;
    logic [63:0]        rdata_q, rdata_d, oaddr_q, oaddr_d, owdata_q, owdata_d;
    logic [63:0]        lane_rdata, lane_merged;
    logic               active;

    assign o_hit = is_dev(i_addr);

    ysyx_210544_mmio_lane u_lane (
        .funct3   (f3_d),
        .off      (addr_d[2:0]),
        .dword    (data_d),
        .wdata    (wdata_d),
        .rdata_c  (lane_rdata),
        .merged_c (lane_merged)
    );

    // Next-state: phase bit selects read (0) or write (1) half of a transaction.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        load_d  = load_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_inc = cnt_q + CNT_W'(1);
        rmw     = !load_q && (f3_q[1:0] != 2'b11);

        case (state_q)
            S_IDLE: begin
                if (i_valid && (i_ren || i_wen) && o_hit && !done_q) begin
                    state_d = S_START;
                    load_d  = i_ren;
                    f3_d    = i_funct3;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    data_d  = 64'h0;
                    cnt_d   = '0;
                    phase_d = !i_ren && (i_funct3[1:0] == 2'b11);
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (bus.i_req) begin
                    state_d = S_ACK;
                    if (!phase_q) data_d = bus.i_rdata;
                    done_d = !(rmw && !phase_q);
                end else if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_ACK: begin
                cnt_d = '0;
                if (rmw && !phase_q) begin
                    phase_d = 1'b1;
                    state_d = S_START;
                end else begin
                    phase_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        active   = (state_d != S_IDLE);
        busy_d   = active;
        start_d  = (state_d == S_START);
        ack_d    = (state_d == S_ACK);
        ren_d    = active && !phase_d;
        wen_d    = active && phase_d;
        oaddr_d  = active ? {addr_d[63:3], 3'b000} : 64'h0;
        owdata_d = wen_d ? lane_merged : 64'h0;
        rdata_d  = (done_d && !err_d && load_d) ? lane_rdata : 64'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 1'b0;
            load_q   <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= 64'h0;
            wdata_q  <= 64'h0;
            data_q   <= 64'h0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            rdata_q  <= 64'h0;
            oaddr_q  <= 64'h0;
            owdata_q <= 64'h0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            load_q   <= load_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            ack_q    <= ack_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            rdata_q  <= rdata_d;
            oaddr_q  <= oaddr_d;
            owdata_q <= owdata_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_rdata     = rdata_q;
    assign bus.o_start = start_q;
    assign bus.o_ack   = ack_q;
    assign bus.o_ren   = ren_q;
    assign bus.o_wen   = wen_q;
    assign bus.o_addr  = oaddr_q;
    assign bus.o_wdata = owdata_q;
endmodule

// File: tb/tb_ysyx_210544_mmio_initiator.sv
// Bench for the MMIO initiator: behavioural responder plus expected-result scoreboard.
module tb_ysyx_210544_mmio_initiator;
    import ysyx_210544_mmio_initiator_pkg::*;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ren, i_wen;
    logic [2:0]  i_funct3;
    logic [63:0] i_addr, i_wdata;
    logic        o_hit, o_busy, o_done, o_err;
    logic [63:0] o_rdata;

    ysyx_210544_mmio_initiator_if bus();

    ysyx_210544_mmio_initiator #(.TIMEOUT(TO)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ren    (i_ren),
        .i_wen    (i_wen),
        .i_funct3 (i_funct3),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .o_hit    (o_hit),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_rdata  (o_rdata),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: req rises the cycle after o_start, drops after o_ack.
    logic        resp_on;
    logic        req_q;
    logic [63:0] rd_q;
    logic [63:0] mem [3];

    function automatic int unsigned dev_idx(input logic [63:0] a);
        if (a == DEV_RTC) return 0;
        if (a == DEV_MTIME) return 1;
        return 2;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
            rd_q  <= 64'h0;
        end else if (bus.o_start && resp_on) begin
            req_q <= 1'b1;
            rd_q  <= mem[dev_idx(bus.o_addr)];
        end else if (bus.o_ack) begin
            req_q <= 1'b0;
        end
    end
    assign bus.i_req   = req_q;
    assign bus.i_rdata = req_q ? rd_q : 64'h0;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        logic        st;
    } exp_t;
    exp_t        sb[$];
    logic [63:0] wq[$];

    int          n_start = 0, n_ack = 0, n_done = 0, n_busy = 0;
    int          start_cyc = 0, done_cyc = 0;
    logic [63:0] start_addr = 64'h0;
    logic [1:0]  start_rw = 2'b00;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_start) begin
                n_start    <= n_start + 1;
                start_cyc  <= cyc;
                start_addr <= bus.o_addr;
                start_rw   <= {bus.o_ren, bus.o_wen};
            end
            if (bus.o_start && bus.o_ack) check("start_with_ack", 64'(bus.o_ack), 64'd0);
            if (o_busy) n_busy <= n_busy + 1;
            if (bus.o_ack) begin
                n_ack <= n_ack + 1;
                if (bus.o_wen) begin
                    if (wq.size() == 0) check("wq_underflow", 64'(wq.size()), 64'd1);
                    else begin
                        check("st_wdata", bus.o_wdata, wq[0]);
                        void'(wq.pop_front());
                    end
                end
            end
            if (o_done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
                if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
                else begin
                    check("rdata", o_rdata, sb[0].rdata);
                    check("err", 64'(o_err), 64'(sb[0].err));
                    check("done_phase", 64'({bus.o_ack, bus.o_ren, bus.o_wen}),
                          sb[0].err ? 64'd0 : (sb[0].st ? 64'd5 : 64'd6));
                    void'(sb.pop_front());
                end
            end
        end
    end

    int issue_cyc = 0;

    task automatic push(input logic [63:0] rd, input logic err, input logic st);
        exp_t e;
        e.rdata = rd; e.err = err; e.st = st;
        sb.push_back(e);
    endtask

    task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd);
        @(posedge clk); #1;
        i_valid = 1'b1; i_ren = ren; i_wen = wen; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        issue_cyc = cyc;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        if (n_done < target) check("done_wait_expired", 64'(n_done), 64'(target));
    endtask

    task automatic wait_start(input int target);
        int k = 0;
        while (n_start < target && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        if (n_start < target) check("start_wait_expired", 64'(n_start), 64'(target));
    endtask

    int s0, a0, d0, b0, first_done;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0;
        i_funct3 = 3'b000; i_addr = 64'h0; i_wdata = 64'h0; resp_on = 1'b1;
        mem[0] = 64'h0; mem[1] = 64'h0; mem[2] = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({o_busy, o_done, o_err}), 64'd0);
        check("rst_bus", 64'({bus.o_start, bus.o_ack, bus.o_ren, bus.o_wen}), 64'd0);
        check("rst_addr", bus.o_addr, 64'h0);
        check("rst_wdata", bus.o_wdata, 64'h0);
        check("rst_rdata", o_rdata, 64'h0);
        rst = 1'b0;

        i_addr = DEV_MTIME + 64'd5; #1;
        check("hit_mtime", 64'(o_hit), 64'd1);
        i_addr = DEV_MTIME + 64'd8; #1;
        check("hit_none", 64'(o_hit), 64'd0);
        i_addr = DEV_RTC; #1;
        check("hit_rtc", 64'(o_hit), 64'd1);

        // LD mtime
        mem[1] = 64'h0000_0001_8000_0000;
        s0 = n_start; a0 = n_ack; d0 = n_done;
        push(64'h0000_0001_8000_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_D, DEV_MTIME, 64'h0);
        wait_done(d0 + 1);
        check("ld_latency", 64'(done_cyc - issue_cyc), 64'd3);
        check("ld_starts", 64'(n_start - s0), 64'd1);
        check("ld_acks", 64'(n_ack - a0), 64'd1);

        // LW / LWU at mtime+4, plus wrapped and byte loads
        mem[1] = 64'h8000_0000_1234_5678;
        d0 = n_done;
        push(64'hffff_ffff_8000_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_W, DEV_MTIME + 64'd4, 64'h0);
        wait_done(d0 + 1);
        check("lw_addr", start_addr, DEV_MTIME);
        push(64'h0000_0000_8000_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_WU, DEV_MTIME + 64'd4, 64'h0);
        wait_done(d0 + 2);
        push(64'h1234_5678_8000_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_D, DEV_MTIME + 64'd4, 64'h0);
        wait_done(d0 + 3);
        push(64'hffff_ffff_ffff_ff80, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_B, DEV_MTIME + 64'd7, 64'h0);
        wait_done(d0 + 4);
        push(64'h0000_0000_0000_0080, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_BU, DEV_MTIME + 64'd7, 64'h0);
        wait_done(d0 + 5);
        push(64'h0000_0000_0000_5678, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_HU, DEV_MTIME, 64'h0);
        wait_done(d0 + 6);

        // SB read-modify-write
        mem[2] = 64'h1111_1111_1111_1111;
        s0 = n_start; a0 = n_ack; d0 = n_done;
        push(64'h0, 1'b0, 1'b1);
        wq.push_back(64'h1111_1111_11ab_1111);
        issue(1'b0, 1'b1, F3_B, DEV_MTIMECMP + 64'd2, 64'hffff_ffff_ffff_ffab);
        wait_done(d0 + 1);
        repeat (2) @(negedge clk);
        #1;
        check("sb_starts", 64'(n_start - s0), 64'd2);
        check("sb_acks", 64'(n_ack - a0), 64'd2);
        check("sb_dones", 64'(n_done - d0), 64'd1);
        check("sb_last_phase", 64'(start_rw), 64'd1);

        // SW wrapping at offset 6, then SD single phase
        d0 = n_done;
        push(64'h0, 1'b0, 1'b1);
        wq.push_back(64'hccdd_1111_1111_aabb);
        issue(1'b0, 1'b1, F3_W, DEV_MTIMECMP + 64'd6, 64'h0000_0000_aabb_ccdd);
        wait_done(d0 + 1);
        s0 = n_start;
        push(64'h0, 1'b0, 1'b1);
        wq.push_back(64'hdead_beef_0123_4567);
        issue(1'b0, 1'b1, F3_D, DEV_MTIMECMP, 64'hdead_beef_0123_4567);
        wait_done(d0 + 2);
        check("sd_starts", 64'(n_start - s0), 64'd1);

        // Timeout: responder silent
        resp_on = 1'b0;
        a0 = n_ack; d0 = n_done;
        push(64'h0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, F3_D, DEV_RTC, 64'h0);
        wait_done(d0 + 1);
        check("to_latency", 64'(done_cyc - start_cyc), 64'(TO));
        check("to_acks", 64'(n_ack - a0), 64'd0);
        resp_on = 1'b1;
        mem[0] = 64'h0123_4567_89ab_cdef;
        push(64'h0123_4567_89ab_cdef, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_D, DEV_RTC, 64'h0);
        wait_done(d0 + 2);

        // Reset during WAIT
        resp_on = 1'b0;
        issue(1'b1, 1'b0, F3_D, DEV_MTIME, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_ctrl", 64'({o_busy, o_done, o_err}), 64'd0);
        check("rstw_bus", 64'({bus.o_start, bus.o_ack, bus.o_ren, bus.o_wen}), 64'd0);
        check("rstw_addr", bus.o_addr, 64'h0);
        check("rstw_rdata", o_rdata, 64'h0);
        rst = 1'b0;
        resp_on = 1'b1;
        mem[1] = 64'h0000_0000_0000_0042;
        d0 = n_done;
        push(64'h42, 1'b0, 1'b0);
        issue(1'b1, 1'b0, F3_D, DEV_MTIME, 64'h0);
        wait_done(d0 + 1);

        // Back-to-back loads with i_valid held
        mem[1] = 64'h0000_0000_0000_7777;
        d0 = n_done; s0 = n_start;
        push(64'h7777, 1'b0, 1'b0);
        push(64'h7777, 1'b0, 1'b0);
        @(posedge clk); #1;
        i_valid = 1'b1; i_ren = 1'b1; i_wen = 1'b0; i_funct3 = F3_D; i_addr = DEV_MTIME;
        wait_done(d0 + 1);
        first_done = done_cyc;
        wait_start(s0 + 2);
        i_valid = 1'b0;
        check("b2b_gap", 64'(start_cyc - first_done), 64'd2);
        wait_done(d0 + 2);

        // Non-hit request is ignored
        @(posedge clk); #1;
        b0 = n_busy;
        i_valid = 1'b1; i_ren = 1'b1; i_addr = 64'h0000_0000_8000_0000;
        repeat (10) @(posedge clk);
        #1;
        i_valid = 1'b0;
        check("nohit_busy", 64'(n_busy - b0), 64'd0);

        check("sb_leftover", 64'(sb.size()), 64'd0);
        check("wq_leftover", 64'(wq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t expected completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
